// File: rtl/bus_arbit_rr4.sv
`default_nettype none
// ============================================================================
//  Module   : bus_arbit_rr4
//  Purpose  : Four-master round-robin bus arbiter with a bounded hold time.
//             Produces registered one-hot grants and an owner index (mux
//             select for the shared bus datapath). An owner that keeps its
//             request while another master is waiting is forced off after
//             MAX_HOLD contested cycles.
//  Ports    : clk                  system clock, rising edge
//             reset_n              asynchronous active-low reset
//             m0_req..m3_req       bus requests from masters 0..3
//             m0_grant..m3_grant   registered one-hot grants
//             m_sel[1:0]           index of the granted master
//             hold_exp             one-cycle pulse, first cycle of a grant
//                                  taken by forced handover
//  Revision : 1.0  initial release
// ============================================================================
module bus_arbit_rr4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       m0_req,
  input  logic       m1_req,
  input  logic       m2_req,
  input  logic       m3_req,
  output logic       m0_grant,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic       m3_grant,
  output logic [1:0] m_sel,
  output logic       hold_exp
);

  // Last counter value before a contested owner is forced off.
  localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [1:0]       r_owner;
  logic [3:0]       r_grant;
  logic [CNT_W-1:0] r_hold_cnt;
  logic             r_hold_exp;

  logic [3:0]       w_req;
  logic [3:0]       w_owner_oh;
  logic             w_own_req;
  logic             w_other_req;
  logic [1:0]       w_cand;
  logic [1:0]       w_next;
  logic             w_found;
  logic [1:0]       w_owner_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_exp_nxt;

  assign w_req       = {m3_req, m2_req, m1_req, m0_req};
  assign w_owner_oh  = 4'b0001 << r_owner;
  assign w_own_req   = w_req[r_owner];
  assign w_other_req = |(w_req & ~w_owner_oh);

  // Search owner+1, owner+2, owner+3 (mod 4); the owner itself is skipped,
  // which is what makes the rotation fair without a separate pointer.
  always_comb begin
    w_next  = r_owner;
    w_found = 1'b0;
    w_cand  = r_owner;
    for (int i = 1; i < 4; i++) begin
      w_cand = r_owner + 2'(i);
      if (!w_found && w_req[w_cand]) begin
        w_next  = w_cand;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_owner_nxt = r_owner;
    w_cnt_nxt   = '0;
    w_exp_nxt   = 1'b0;
    if (w_own_req && !w_other_req) begin
      w_owner_nxt = r_owner;
    end else if (w_own_req && (r_hold_cnt != c_HOLD_LAST)) begin
      // Contested but still inside the hold window.
      w_cnt_nxt   = r_hold_cnt + 1'b1;
    end else if (w_own_req) begin
      // Hold window exhausted: forced handover.
      w_owner_nxt = w_next;
      w_exp_nxt   = 1'b1;
    end else if (w_other_req) begin
      w_owner_nxt = w_next;
    end else begin
      // Nobody wants the bus: park on master 0.
      w_owner_nxt = 2'd0;
    end
  end

  // Grants are kept as their own register so the outputs come straight
  // from flops rather than through a decoder.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner    <= 2'd0;
      r_grant    <= 4'b0001;
      r_hold_cnt <= '0;
      r_hold_exp <= 1'b0;
    end else begin
      r_owner    <= w_owner_nxt;
      r_grant    <= 4'b0001 << w_owner_nxt;
      r_hold_cnt <= w_cnt_nxt;
      r_hold_exp <= w_exp_nxt;
    end
  end

  assign m0_grant = r_grant[0];
  assign m1_grant = r_grant[1];
  assign m2_grant = r_grant[2];
  assign m3_grant = r_grant[3];
  assign m_sel    = r_owner;
  assign hold_exp = r_hold_exp;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbit_rr4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_arbit_rr4
//  Purpose  : Self-checking bench for bus_arbit_rr4 with a behavioural
//             reference model of the round-robin / hold-limit rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bus_arbit_rr4;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic       g0, g1, g2, g3;
  logic [1:0] m_sel;
  logic       hold_exp;
  logic [3:0] grants;

  int n_tests = 0;
  int n_fail  = 0;
  logic started = 1'b0;

  // Reference model state
  int         m_owner;
  int         m_cnt;
  logic       m_exp;
  logic [3:0] exp_g;

  assign grants = {g3, g2, g1, g0};

  always #5 clk = ~clk;

  bus_arbit_rr4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .m0_req   (req[0]),
    .m1_req   (req[1]),
    .m2_req   (req[2]),
    .m3_req   (req[3]),
    .m0_grant (g0),
    .m1_grant (g1),
    .m2_grant (g2),
    .m3_grant (g3),
    .m_sel    (m_sel),
    .hold_exp (hold_exp)
  );

  task automatic model_reset();
    m_owner = 0;
    m_cnt   = 0;
    m_exp   = 1'b0;
    exp_g   = 4'b0001;
  endtask

  // Applies the arbitration rules to the request vector seen at an edge.
  task automatic model_step();
    int  nxt;
    bit  own, other;
    own   = req[m_owner];
    other = 1'b0;
    for (int k = 0; k < 4; k++)
      if (k != m_owner && req[k]) other = 1'b1;
    nxt = m_owner;
    for (int k = 3; k >= 1; k--)
      if (req[(m_owner + k) % 4]) nxt = (m_owner + k) % 4;
    m_exp = 1'b0;
    if (own && !other) begin
      m_cnt = 0;
    end else if (own && other && m_cnt < MAX_HOLD - 1) begin
      m_cnt = m_cnt + 1;
    end else if (own && other) begin
      m_owner = nxt; m_cnt = 0; m_exp = 1'b1;
    end else if (other) begin
      m_owner = nxt; m_cnt = 0;
    end else begin
      m_owner = 0; m_cnt = 0;
    end
    exp_g = 4'b0001 << m_owner;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Structural properties checked every cycle once reset has been released.
  always @(negedge clk) begin
    if (started && reset_n) begin
      n_tests++;
      if ($countones(grants) != 1 || grants[m_sel] !== 1'b1) begin
        n_fail++;
        $display("FAIL onehot_sel t=%0t grants=%b m_sel=%0d required one grant high at m_sel",
                 $time, grants, m_sel);
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    req     = 4'b0000;
    model_reset();
    #13;
    n_tests++;
    if ({grants, m_sel, hold_exp} !== {4'b0001, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state got %b/%0d/%b required 0001/0/0", grants, m_sel, hold_exp);
    end
    reset_n = 1'b1;
    started = 1'b1;
    tick();
    n_tests++;
    if ({grants, m_sel, hold_exp} !== {4'b0001, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL park_after_reset got %b/%0d/%b required 0001/0/0", grants, m_sel, hold_exp);
    end
  endtask

  task automatic test_simple_grant();
    req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if (grants !== 4'b0100 || m_sel !== 2'd2) begin
        n_fail++;
        $display("FAIL simple_grant cyc%0d got %b/%0d required 0100/2", c, grants, m_sel);
      end
    end
    req = 4'b0000;
    tick();
    n_tests++;
    if (grants !== 4'b0001 || m_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL simple_release got %b/%0d required 0001/0", grants, m_sel);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] seq_req [4] = '{4'b1111, 4'b1101, 4'b1001, 4'b0001};
    logic [3:0] seq_exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req = 4'b0010;
    tick();
    n_tests++;
    if (grants !== 4'b0010) begin
      n_fail++;
      $display("FAIL rr_setup got %b required 0010", grants);
    end
    for (int s = 0; s < 4; s++) begin
      req = seq_req[s];
      tick();
      n_tests++;
      if (grants !== seq_exp[s] || grants !== exp_g) begin
        n_fail++;
        $display("FAIL rr_step%0d got %b required %b (model %b)", s, grants, seq_exp[s], exp_g);
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_hold_limit();
    int keep = 0;
    req = 4'b0010;
    tick();
    req = 4'b1010;
    for (int c = 0; c < MAX_HOLD; c++) begin
      tick();
      if (grants === 4'b0010) keep++;
    end
    n_tests++;
    if (keep != MAX_HOLD - 1) begin
      n_fail++;
      $display("FAIL hold_keep_edges got %0d required %0d", keep, MAX_HOLD - 1);
    end
    n_tests++;
    if (grants !== 4'b1000 || hold_exp !== 1'b1 || m_sel !== 2'd3) begin
      n_fail++;
      $display("FAIL hold_handover got %b/%0d/%b required 1000/3/1", grants, m_sel, hold_exp);
    end
    tick();
    n_tests++;
    if (hold_exp !== 1'b0 || grants !== 4'b1000) begin
      n_fail++;
      $display("FAIL hold_pulse_width got %b/%b required 1000/0", grants, hold_exp);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_coincident_release();
    req = 4'b0010;
    tick();
    req = 4'b1010;
    for (int c = 0; c < MAX_HOLD - 1; c++) tick();
    n_tests++;
    if (grants !== 4'b0010) begin
      n_fail++;
      $display("FAIL coinc_pre got %b required 0010", grants);
    end
    req = 4'b1000;
    tick();
    n_tests++;
    if (grants !== 4'b1000 || hold_exp !== 1'b0) begin
      n_fail++;
      $display("FAIL coinc_release got %b/%b required 1000/0", grants, hold_exp);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_async_reset();
    req = 4'b0100;
    tick();
    n_tests++;
    if (grants !== 4'b0100) begin
      n_fail++;
      $display("FAIL areset_setup got %b required 0100", grants);
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({grants, m_sel, hold_exp} !== {4'b0001, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL areset_immediate got %b/%0d/%b required 0001/0/0", grants, m_sel, hold_exp);
    end
    req = 4'b0000;
    model_reset();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      tick();
      n_tests++;
      if (grants !== exp_g || m_sel !== 2'(m_owner) || hold_exp !== m_exp) begin
        n_fail++;
        $display("FAIL random cyc%0d req=%b got %b/%0d/%b required %b/%0d/%b",
                 c, req, grants, m_sel, hold_exp, exp_g, m_owner, m_exp);
      end
    end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_simple_grant();
    test_round_robin();
    test_hold_limit();
    test_coincident_release();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
